mult_div_unit: RTL and testbench

//  Iterative 32-bit multiply/divide unit feeding the HI/LO register pair.

---
 rtl/mult_div_unit.sv | 247 ++++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit that feeds the HI/LO register pair.
//   MULT/MULTU use a shift-add multiplier, DIV/DIVU a restoring divider; both
//   run on operand magnitudes for WIDTH cycles, then the sign is fixed and a
//   single write pulse is issued (HiOut -> WriteData1, LoOut -> WriteData2).
//
//   Optional feature macro: MULT_DIV_MACC_EN
//     defined   : Op 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU are legal;
//                 {HiOut,LoOut} = {HiIn,LoIn} +/- product (mod 2^(2*WIDTH)).
//     undefined : Op 1xx is rejected, HiIn/LoIn are ignored.
//
// Ports
//   Clk        in   clock, all state changes on posedge
//   Reset      in   synchronous, active-high
//   Start      in   request, accepted when Busy=0 and Op is legal
//   Op[2:0]    in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 1xx accumulate
//   A, B       in   rs / rt operands, sampled at the accept edge
//   HiIn, LoIn in   current HI/LO, used only by accumulate ops
//   Busy       out  high from the cycle after accept through the Done cycle
//   Done       out  one-cycle completion pulse
//   WriteHi    out  same as Done
//   WriteLo    out  same as Done
//   HiOut      out  product high half or remainder (held until next Done)
//   LoOut      out  product low half or quotient (held until next Done)
//   DivByZero  out  pulses with Done when a DIV/DIVU had B=0
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] HiIn,
  input  logic [WIDTH-1:0] LoIn,
  output logic             Busy,
  output logic             Done,
  output logic             WriteHi,
  output logic             WriteLo,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's-complement negate when neg is set; magnitude of the most negative
  // value comes out as the unsigned 2^(WIDTH-1), which is what we want.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic             neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x,
                                                   input logic               neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz_out;
  logic [WIDTH-1:0] r_hi_out;
  logic [WIDTH-1:0] r_lo_out;

  // Operation attributes and working registers captured at accept.
  logic             r_is_div;
  logic             r_neg_lo;   // negate product / quotient
  logic             r_neg_hi;   // negate remainder
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;       // product high / partial remainder
  logic [WIDTH-1:0] r_lo;       // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] r_b;        // multiplicand / divisor magnitude
`ifdef MULT_DIV_MACC_EN
  logic             r_is_acc;
  logic             r_acc_sub;
  logic [WIDTH-1:0] r_hi_in;
  logic [WIDTH-1:0] r_lo_in;
`else
  logic             w_unused_acc;
  assign w_unused_acc = ^{HiIn, LoIn};
`endif

  logic                    w_legal;
  logic                    w_accept;
  logic                    w_op_signed;
  logic                    w_op_div;
  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [WIDTH-1:0]        w_a_mag;
  logic [WIDTH-1:0]        w_b_mag;

`ifdef MULT_DIV_MACC_EN
  assign w_legal = 1'b1;
`else
  assign w_legal = ~Op[2];
`endif

  assign w_accept    = Start & ~r_busy & w_legal;
  assign w_op_signed = ~Op[0];
  assign w_op_div    = ~Op[2] & Op[1];
  assign w_a_s       = A;
  assign w_b_s       = B;
  assign w_a_neg     = w_op_signed & (w_a_s < 0);
  assign w_b_neg     = w_op_signed & (w_b_s < 0);
  assign w_a_mag     = cond_neg(A, w_a_neg);
  assign w_b_mag     = cond_neg(B, w_b_neg);

  // ---- iteration stage: one shift-add or restoring-subtract step ----
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  assign w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
  // Partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the top bit of the difference is the borrow.
  assign w_div_trial = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};
  assign w_div_ge    = ~w_div_trial[WIDTH];

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_is_div) begin
      w_hi_nxt = w_div_ge ? w_div_trial[WIDTH-1:0] : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
      w_lo_nxt = {r_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_hi_nxt = w_mul_sum[WIDTH:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // ---- result stage: sign fix-up, divide-by-zero override, accumulate ----
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_prod_fix = cond_neg2({r_hi, r_lo}, r_neg_lo);

  always_comb begin
    w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      // With a zero divisor every trial succeeds, so the remainder register
      // ends up holding |A|; the sign fix then restores A itself.
      w_res_hi = cond_neg(r_hi, r_neg_hi);
      w_res_lo = r_dbz ? '1 : cond_neg(r_lo, r_neg_lo);
    end
`ifdef MULT_DIV_MACC_EN
    else if (r_is_acc) begin
      {w_res_hi, w_res_lo} = r_acc_sub ? ({r_hi_in, r_lo_in} - w_prod_fix)
                                       : ({r_hi_in, r_lo_in} + w_prod_fix);
    end
`endif
  end

  // ---- control FSM and registered outputs ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      r_hi_out  <= '0;
      r_lo_out  <= '0;
    end else begin
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Busy covers the Done cycle, which is spent back in IDLE.
          if (r_done) begin
            r_busy <= 1'b0;
          end
          if (w_accept) begin
            r_state <= S_RUN;
            r_cnt   <= CW'(WIDTH - 1);
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b1;
          r_dbz_out <= r_is_div & r_dbz;
          r_hi_out  <= w_res_hi;
          r_lo_out  <= w_res_lo;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---- datapath registers: operand capture and iteration ----
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_is_div <= w_op_div;
      r_neg_lo <= w_a_neg ^ w_b_neg;
      r_neg_hi <= w_a_neg;
      r_dbz    <= w_op_div & (B == '0);
      r_b      <= w_op_div ? w_b_mag : w_a_mag;
      r_hi     <= '0;
      r_lo     <= w_op_div ? w_a_mag : w_b_mag;
`ifdef MULT_DIV_MACC_EN
      r_is_acc  <= Op[2];
      r_acc_sub <= Op[1];
      r_hi_in   <= HiIn;
      r_lo_in   <= LoIn;
`endif
    end else if (r_state == S_RUN) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign WriteHi   = r_done;
  assign WriteLo   = r_done;
  assign HiOut     = r_hi_out;
  assign LoOut     = r_lo_out;
  assign DivByZero = r_dbz_out;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset, Start;
  logic [2:0]   Op;
  logic [W-1:0] A, B, HiIn, LoIn;
  logic         Busy, Done, WriteHi, WriteLo, DivByZero;
  logic [W-1:0] HiOut, LoOut;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiIn(HiIn), .LoIn(LoIn), .Busy(Busy), .Done(Done), .WriteHi(WriteHi),
    .WriteLo(WriteLo), .HiOut(HiOut), .LoOut(LoOut), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hin, lin;
    logic [W-1:0] hi, lo;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi, lo;
    logic         dbz;
    int           t0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference model: {dbz, hi, lo}.
  function automatic logic [64:0] model(input logic [2:0] op, input logic [W-1:0] a, b, hin, lin);
    longint          sa, sb_v, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p, acc;
    sa = longint'($signed(a));
    sb_v = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    if (!op[2] && op[1]) begin
      if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
      if (!op[0]) begin
        q = sa / sb_v; r = sa % sb_v;
        p = {r[31:0], q[31:0]};
      end else begin
        uq = ua / ub; ur = ua % ub;
        p = {ur[31:0], uq[31:0]};
      end
      return {1'b0, p};
    end
    if (op[0]) p = ua * ub;
    else       p = sa * sb_v;
    if (!op[2]) return {1'b0, p};
    acc = {hin, lin};
    return {1'b0, (op[1] ? acc - p : acc + p)};
  endfunction

  // One cycle: advance to the next negedge and score any completion.
  task automatic step();
    exp_t e;
    @(negedge Clk);
    chk("writehi_eq_done", {63'd0, WriteHi}, {63'd0, Done});
    chk("writelo_eq_done", {63'd0, WriteLo}, {63'd0, Done});
    if (Done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("hi", 64'(HiOut), 64'(e.hi));
        chk("lo", 64'(LoOut), 64'(e.lo));
        chk("divbyzero", 64'(DivByZero), 64'(e.dbz));
        chk("latency", 64'(cyc - e.t0), 64'(W + 1));
        chk("busy_in_done", 64'(Busy), 64'd1);
      end
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, b, hin, lin,
                          input logic [W-1:0] ehi, elo, input logic edbz);
    exp_t e;
    Op = op; A = a; B = b; HiIn = hin; LoIn = lin; Start = 1'b1;
    @(posedge Clk);
    #1;
    e.hi = ehi; e.lo = elo; e.dbz = edbz; e.t0 = cyc;
    sb.push_back(e);
    Start = 1'b0;
    chk("busy_after_accept", 64'(Busy), 64'd1);
  endtask

  task automatic wait_done(input int max);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max; i++) begin
      step();
      if (done_cnt != d0) return;
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b, hin, lin);
    logic [64:0] m;
    m = model(op, a, b, hin, lin);
    start_op(op, a, b, hin, lin, m[63:32], m[31:0], m[64]);
    wait_done(W + 10);
    step();
    chk("busy_after_done", 64'(Busy), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int d0;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb, rh, rl;

    vecs[0] = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{3'd3, 32'd100,        32'd7,         32'd0, 32'd0, 32'd2,         32'd14,        1'b0};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9,  32'd2,         32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0,         32'h8000_0000, 1'b0};
    vecs[4] = '{3'd3, 32'h1234,       32'd0,         32'd0, 32'd0, 32'h1234,      32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{3'd2, 32'hFFFF_FFF0,  32'd0,         32'd0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[7] = '{3'd0, 32'h8000_0000,  32'h8000_0000, 32'd0, 32'd0, 32'h4000_0000, 32'd0,         1'b0};
    vecs[8] = '{3'd2, 32'd7,          32'hFFFF_FFFE, 32'd0, 32'd0, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[9] = '{3'd0, 32'd0,          32'h0001_2345, 32'd0, 32'd0, 32'd0,         32'd0,         1'b0};

    Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0; HiIn = '0; LoIn = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_writehi", 64'(WriteHi), 64'd0);
    chk("rst_writelo", 64'(WriteLo), 64'd0);
    chk("rst_dbz", 64'(DivByZero), 64'd0);
    chk("rst_hiout", 64'(HiOut), 64'd0);
    chk("rst_loout", 64'(LoOut), 64'd0);
    Reset = 1'b0;
    step();

    // Table vectors, issued back to back (Start in the cycle after Done).
    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hin, vecs[i].lin,
               vecs[i].hi, vecs[i].lo, vecs[i].dbz);
      wait_done(W + 10);
      step();
      chk("busy_after_done", 64'(Busy), 64'd0);
    end

    // Random operations scored against the reference model.
    for (int i = 0; i < 12; i++) begin
`ifdef MULT_DIV_MACC_EN
      rop = 3'($urandom_range(0, 7));
`else
      rop = 3'($urandom_range(0, 3));
`endif
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 300)) : $urandom);
      rh = $urandom;
      rl = $urandom;
      run_op(rop, ra, rb, rh, rl);
    end

    // Start while busy is ignored: exactly one completion, MULTU result.
    d0 = done_cnt;
    start_op(3'd1, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 32'd15, 1'b0);
    repeat (4) step();
    Op = 3'd2; A = 32'd9; B = 32'd3; Start = 1'b1;
    step();
    Start = 1'b0;
    wait_done(W + 10);
    repeat (40) step();
    chk("single_done", 64'(done_cnt - d0), 64'd1);
    chk("busy_idle", 64'(Busy), 64'd0);

    // Reset mid-operation aborts without a write pulse.
    start_op(3'd3, 32'd1000, 32'd3, 32'd0, 32'd0, 32'd1, 32'd333, 1'b0);
    repeat (9) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    chk("abort_writehi", 64'(WriteHi), 64'd0);
    chk("abort_loout", 64'(LoOut), 64'd0);
    sb.delete();
    d0 = done_cnt;
    repeat (40) step();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    // Reset wins over Start in the same cycle.
    Reset = 1'b1; Op = 3'd1; A = 32'd2; B = 32'd2; Start = 1'b1;
    step();
    Reset = 1'b0; Start = 1'b0;
    step();
    chk("rst_prio_busy", 64'(Busy), 64'd0);
    d0 = done_cnt;
    repeat (40) step();
    chk("rst_prio_no_done", 64'(done_cnt - d0), 64'd0);

`ifdef MULT_DIV_MACC_EN
    start_op(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    wait_done(W + 10);
    step();
    start_op(3'd6, 32'd3, 32'hFFFF_FFFE, 32'd0, 32'd10, 32'd0, 32'd16, 1'b0);
    wait_done(W + 10);
    step();
    start_op(3'd7, 32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(W + 10);
    step();
`else
    // Accumulate ops are rejected in this build.
    d0 = done_cnt;
    Op = 3'd5; A = 32'd1; B = 32'd1; HiIn = 32'd0; LoIn = 32'hFFFF_FFFF; Start = 1'b1;
    step();
    Start = 1'b0;
    chk("illegal_busy", 64'(Busy), 64'd0);
    repeat (40) step();
    chk("illegal_busy_later", 64'(Busy), 64'd0);
    chk("illegal_no_done", 64'(done_cnt - d0), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
